// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: width defaults, FSM state
// encoding and requester identifiers.
package dmem_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_IO  = 1'b1
  } req_id_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side bundles for the data-memory arbiter.
// Handshake: req (with we/addr/wdata) is held by the requester until gnt; gnt and
// rvalid are one-cycle pulses; rdata is valid with rvalid and holds between responses.
interface dmem_req_if
  import dmem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

interface dmem_mem_if
  import dmem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          en;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (output en, we, addr, wdata, input rdata);
  modport slave  (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker. The pointer names the requester that wins a tie and
// moves to the non-winner whenever a grant is taken.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,      // bit 0 = CPU, bit 1 = IO
  input  logic       advance_i,
  output logic       valid_o,
  output req_id_e    winner_o,
  output req_id_e    ptr_o
);

  req_id_e ptr_q, ptr_d;

  always_comb begin
    valid_o = |req_i;
    if (req_i[0] && req_i[1]) begin
      winner_o = ptr_q;
    end else if (req_i[1]) begin
      winner_o = REQ_IO;
    end else begin
      winner_o = REQ_CPU;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (winner_o == REQ_CPU) ? REQ_IO : REQ_CPU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= REQ_CPU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU and the I/O requester:
// IDLE picks a winner, ACCESS drives the memory strobe, RESP returns read data.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_req_if.slave  cpu_if,
  dmem_req_if.slave  io_if,
  dmem_mem_if.master mem_if,
  output logic [1:0] dbg_state_o,
  output req_id_e    dbg_ptr_o
);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_ACCESS = ST_ACCESS;
  localparam logic [1:0] S_RESP   = ST_RESP;

  logic [1:0]    state_q, state_d;
  req_id_e       win_q, win_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] io_rdata_q, io_rdata_d;
  logic          arb_valid;
  logic          arb_advance;
  req_id_e       arb_winner;
  logic          in_access;
  logic          in_resp;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     ({io_if.req, cpu_if.req}),
    .advance_i (arb_advance),
    .valid_o   (arb_valid),
    .winner_o  (arb_winner),
    .ptr_o     (dbg_ptr_o)
  );

  assign arb_advance = (state_q == S_IDLE) && arb_valid;

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    io_rdata_d  = io_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          state_d = S_ACCESS;
          win_d   = arb_winner;
          if (arb_winner == REQ_IO) begin
            we_d    = io_if.we;
            addr_d  = io_if.addr;
            wdata_d = io_if.wdata;
          end else begin
            we_d    = cpu_if.we;
            addr_d  = cpu_if.addr;
            wdata_d = cpu_if.wdata;
          end
        end
      end
      S_ACCESS: state_d = we_q ? S_IDLE : S_RESP;
      S_RESP: begin
        // Keep the delivered word so rdata holds until the next response.
        state_d = S_IDLE;
        if (win_q == REQ_IO) begin
          io_rdata_d = mem_if.rdata;
        end else begin
          cpu_rdata_d = mem_if.rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      win_q       <= REQ_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      io_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      io_rdata_q  <= io_rdata_d;
    end
  end

  assign in_access = (state_q == S_ACCESS);
  assign in_resp   = (state_q == S_RESP);

  assign mem_if.en    = in_access;
  assign mem_if.we    = in_access && we_q;
  assign mem_if.addr  = addr_q;
  assign mem_if.wdata = wdata_q;

  assign cpu_if.gnt    = in_access && (win_q == REQ_CPU);
  assign io_if.gnt     = in_access && (win_q == REQ_IO);
  assign cpu_if.rvalid = in_resp && (win_q == REQ_CPU);
  assign io_if.rvalid  = in_resp && (win_q == REQ_IO);
  assign cpu_if.rdata  = cpu_if.rvalid ? mem_if.rdata : cpu_rdata_q;
  assign io_if.rdata   = io_if.rvalid ? mem_if.rdata : io_rdata_q;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-timeline model, per-cycle compare, directed scenarios.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int TW = 2 + AW + DW;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  req_id_e    dbg_ptr;

  dmem_req_if #(.AW(AW), .DW(DW)) cpu_bus ();
  dmem_req_if #(.AW(AW), .DW(DW)) io_bus ();
  dmem_mem_if #(.AW(AW), .DW(DW)) mem_bus ();

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_if      (cpu_bus),
    .io_if       (io_bus),
    .mem_if      (mem_bus),
    .dbg_state_o (dbg_state),
    .dbg_ptr_o   (dbg_ptr)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- memory behind the arbiter ----------------
  logic [DW-1:0] mem_arr [0:4095];
  logic [DW-1:0] ref_mem [0:4095];

  initial begin
    forever begin
      @(posedge clk);
      if (mem_bus.en === 1'b1) begin
        if (mem_bus.we) mem_arr[mem_bus.addr] = mem_bus.wdata;
        else            mem_bus.rdata = mem_arr[mem_bus.addr];
      end
    end
  end

  // ---------------- model: transaction timeline ----------------
  // A request seen at edge e starts an access occupying cycle e (plus e+1 for a read);
  // the next decision is taken at edge e+2 (write) or e+3 (read).
  int            m_edge    = 0;
  int            free_edge = 0;
  bit            tx_valid  = 0;
  bit            tx_who    = 0;
  bit            tx_we     = 0;
  int            tx_start  = 0;
  logic [AW-1:0] tx_addr   = '0;
  logic [DW-1:0] tx_wdata  = '0;
  logic [DW-1:0] tx_rdata  = '0;
  req_id_e       m_ptr     = REQ_CPU;
  logic [DW-1:0] e_cpu_rdata = '0;
  logic [DW-1:0] e_io_rdata  = '0;
  logic [TW-1:0] exp_q[$];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_edge = 0; free_edge = 0; tx_valid = 0; m_ptr = REQ_CPU;
        e_cpu_rdata = '0; e_io_rdata = '0;
        exp_q.delete();
      end else begin
        m_edge++;
        if (tx_valid && !tx_we && m_edge == tx_start + 1) begin
          if (tx_who) e_io_rdata = tx_rdata;
          else        e_cpu_rdata = tx_rdata;
        end
        if (m_edge >= free_edge && (cpu_bus.req || io_bus.req)) begin
          if (cpu_bus.req && io_bus.req) tx_who = (m_ptr == REQ_IO);
          else                           tx_who = io_bus.req;
          tx_we    = tx_who ? io_bus.we    : cpu_bus.we;
          tx_addr  = tx_who ? io_bus.addr  : cpu_bus.addr;
          tx_wdata = tx_who ? io_bus.wdata : cpu_bus.wdata;
          tx_valid = 1;
          tx_start = m_edge;
          free_edge = m_edge + (tx_we ? 2 : 3);
          m_ptr = tx_who ? REQ_CPU : REQ_IO;
          if (tx_we) ref_mem[tx_addr] = tx_wdata;
          else       tx_rdata = ref_mem[tx_addr];
          exp_q.push_back({tx_who, tx_we, tx_addr, tx_wdata});
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  int            last_cpu_gnt = -1, last_io_gnt = -1;
  int            last_cpu_rv = -1, last_io_rv = -1;
  int            cpu_rv_n = 0, io_rv_n = 0;
  logic [DW-1:0] last_cpu_rv_data = '0, last_io_rv_data = '0;
  logic [AW-1:0] last_gnt_addr = '0;
  logic [DW-1:0] last_gnt_wdata = '0;
  logic          last_gnt_we = 0;
  bit            alt_on = 0, alt_last = 0;
  int            alt_n = 0;

  initial begin
    logic [TW-1:0] e;
    bit acc, rsp, gwho;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_cpu_gnt", cpu_bus.gnt, 0);
        check("rst_io_gnt", io_bus.gnt, 0);
        check("rst_cpu_rvalid", cpu_bus.rvalid, 0);
        check("rst_io_rvalid", io_bus.rvalid, 0);
        check("rst_mem_en", mem_bus.en, 0);
        check("rst_mem_we", mem_bus.we, 0);
        check("rst_mem_addr", mem_bus.addr, 0);
        check("rst_mem_wdata", mem_bus.wdata, 0);
        check("rst_cpu_rdata", cpu_bus.rdata, 0);
        check("rst_io_rdata", io_bus.rdata, 0);
        check("rst_ptr", dbg_ptr, REQ_CPU);
      end else begin
        acc = tx_valid && (m_edge == tx_start);
        rsp = tx_valid && !tx_we && (m_edge == tx_start + 1);
        check("cpu_gnt", cpu_bus.gnt, acc && !tx_who);
        check("io_gnt", io_bus.gnt, acc && tx_who);
        check("mem_en", mem_bus.en, acc);
        check("mem_we", mem_bus.we, acc && tx_we);
        check("cpu_rvalid", cpu_bus.rvalid, rsp && !tx_who);
        check("io_rvalid", io_bus.rvalid, rsp && tx_who);
        check("cpu_rdata", cpu_bus.rdata, e_cpu_rdata);
        check("io_rdata", io_bus.rdata, e_io_rdata);
        check("ptr", dbg_ptr, m_ptr);
        check("one_gnt", cpu_bus.gnt & io_bus.gnt, 0);
        check("one_rvalid", cpu_bus.rvalid & io_bus.rvalid, 0);
        if (cpu_bus.gnt === 1'b1 || io_bus.gnt === 1'b1) begin
          gwho = io_bus.gnt;
          check("gnt_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("gnt_who", gwho, e[TW-1]);
            check("gnt_we", mem_bus.we, e[TW-2]);
            check("gnt_addr", mem_bus.addr, e[AW+DW-1:DW]);
            if (e[TW-2]) check("gnt_wdata", mem_bus.wdata, e[DW-1:0]);
          end
          if (alt_on) begin
            if (alt_n > 0) check("alternate", gwho != alt_last, 1);
            alt_last = gwho;
            alt_n++;
          end
          if (gwho) last_io_gnt = cyc; else last_cpu_gnt = cyc;
          last_gnt_addr  = mem_bus.addr;
          last_gnt_wdata = mem_bus.wdata;
          last_gnt_we    = mem_bus.we;
        end
        if (cpu_bus.rvalid === 1'b1) begin
          cpu_rv_n++; last_cpu_rv = cyc; last_cpu_rv_data = cpu_bus.rdata;
        end
        if (io_bus.rvalid === 1'b1) begin
          io_rv_n++; last_io_rv = cyc; last_io_rv_data = io_bus.rdata;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input bit who, input logic r, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (who) begin
      io_bus.req = r; io_bus.we = we; io_bus.addr = a; io_bus.wdata = d;
    end else begin
      cpu_bus.req = r; cpu_bus.we = we; cpu_bus.addr = a; cpu_bus.wdata = d;
    end
  endtask

  // Called just after a rising edge; holds req until gnt, drops it after the next edge.
  task automatic access(input bit who, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int set_c, output int gnt_c);
    bit got;
    got = 0;
    gnt_c = -1;
    set_req(who, 1'b1, we, a, d);
    set_c = cyc;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((who ? io_bus.gnt : cpu_bus.gnt) === 1'b1) begin
        got = 1;
        gnt_c = cyc;
      end
    end
    check("gnt_timeout", got, 1);
    @(posedge clk);
    #1;
    set_req(who, 1'b0, we, a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed scenarios ----------------
  int s_c, g_c, s_i, g_i, rv_before;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_arr[i] = 16'hA5A5 ^ 16'(i);
      ref_mem[i] = 16'hA5A5 ^ 16'(i);
    end
    mem_bus.rdata = '0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("lit_rst_state", dbg_state, 0);
    check("lit_rst_cpu_rdata", cpu_bus.rdata, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Both request out of reset: CPU read wins, IO write follows after CPU's response.
    fork
      access(0, 1'b0, 12'h001, 16'h0000, s_c, g_c);
      access(1, 1'b1, 12'hFFF, 16'h1234, s_i, g_i);
    join
    check("lit_pair1_cpu_gnt_lat", g_c - s_c, 1);
    check("lit_pair1_io_gnt_lat", g_i - s_i, 4);
    check("lit_pair1_cpu_rv_lat", last_cpu_rv - s_c, 2);
    check("lit_pair1_cpu_rdata", last_cpu_rv_data, 16'hA5A4);
    idle(2);

    // Second pair: IO took the last grant, so the pointer names the CPU.
    fork
      access(0, 1'b1, 12'h002, 16'h1111, s_c, g_c);
      access(1, 1'b0, 12'hFFF, 16'h0000, s_i, g_i);
    join
    check("lit_pair2_cpu_gnt_lat", g_c - s_c, 1);
    check("lit_pair2_io_gnt_lat", g_i - s_i, 3);
    idle(2);
    check("lit_pair2_io_rv_lat", last_io_rv - s_i, 4);
    check("lit_pair2_io_rdata_top", last_io_rv_data, 16'h1234);

    // Lone CPU write, then read-back.
    rv_before = cpu_rv_n;
    access(0, 1'b1, 12'h010, 16'hBEEF, s_c, g_c);
    check("lit_wr_gnt_lat", g_c - s_c, 1);
    check("lit_wr_addr", last_gnt_addr, 12'h010);
    check("lit_wr_data", last_gnt_wdata, 16'hBEEF);
    check("lit_wr_we", last_gnt_we, 1);
    idle(2);
    check("lit_wr_no_rvalid", cpu_rv_n, rv_before);
    access(0, 1'b0, 12'h010, 16'h0000, s_c, g_c);
    idle(2);
    check("lit_rd_gnt_lat", g_c - s_c, 1);
    check("lit_rd_rv_lat", last_cpu_rv - s_c, 2);
    check("lit_rd_data", last_cpu_rv_data, 16'hBEEF);

    // Address 0 boundary; CPU drops req right after capture and still gets its data.
    access(1, 1'b1, 12'h000, 16'h5A5A, s_i, g_i);
    idle(1);
    set_req(0, 1'b1, 1'b0, 12'h000, 16'h0000);
    s_c = cyc;
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 1'b0, 12'h000, 16'h0000);
    idle(3);
    check("lit_drop_gnt_lat", last_cpu_gnt - s_c, 1);
    check("lit_drop_rv_lat", last_cpu_rv - s_c, 2);
    check("lit_drop_rdata", last_cpu_rv_data, 16'h5A5A);

    // Reset during the response cycle of an IO read.
    rv_before = io_rv_n;
    access(1, 1'b0, 12'hFFF, 16'h0000, s_i, g_i);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("lit_abort_io_rvalid", io_bus.rvalid, 0);
    check("lit_abort_mem_en", mem_bus.en, 0);
    check("lit_abort_ptr", dbg_ptr, REQ_CPU);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
    check("lit_abort_no_rvalid", io_rv_n, rv_before);
    check("lit_abort_io_rdata", io_bus.rdata, 0);
    fork
      access(0, 1'b1, 12'h020, 16'h0F0F, s_c, g_c);
      access(1, 1'b1, 12'h021, 16'hF0F0, s_i, g_i);
    join
    check("lit_post_rst_cpu_first", g_c - s_c, 1);
    check("lit_post_rst_io_next", g_i - s_i, 3);
    idle(2);

    // Both requesters saturate the arbiter for 20 accesses.
    alt_on = 1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          int sc, gc;
          access(0, (i % 2 == 0), 12'h100 + 12'(i / 2), 16'hC000 + 16'(i), sc, gc);
        end
      end
      begin
        for (int i = 0; i < 10; i++) begin
          int sc, gc;
          access(1, (i % 3 != 1), 12'h200 + 12'(i), 16'hD000 + 16'(i), sc, gc);
        end
      end
    join
    idle(4);
    alt_on = 0;
    check("lit_alt_count", alt_n, 20);
    check("lit_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual still running, required finished by 100000");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
